// File: rtl/local_port_arbiter.sv
// Round-robin injection arbiter for one router local port: one send per slot,
// a fixed idle gap after every send, and per-step packet counting.
//
// state | meaning
// IDLE  | arbitrate, or close a pending step
// SEND  | write strobe/grant asserted for the winner
// GAP   | enforced idle cycles after a send
// CLOSE | step closing; step_done and count clear land on exit
module local_port_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int PACKET_SIZE = 32,
  parameter int GAP_CYCLES  = 4,
  parameter int CNT_WIDTH   = 10
) (
  input  logic                           rt_clk,
  input  logic                           rt_reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*PACKET_SIZE-1:0] packet_in,
  input  logic                           port_full,
  input  logic                           step_end,
  output logic                           write_req,
  output logic [PACKET_SIZE-1:0]         spike_packet,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           step_done,
  output logic [CNT_WIDTH-1:0]           sent_count
);

  localparam int PTR_W     = $clog2(NUM_REQ);
  localparam int GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {IDLE, SEND, GAP, CLOSE} state_t;

  state_t               state;
  logic [PTR_W-1:0]     ptr;
  logic [GAP_W-1:0]     gap_cnt;
  logic                 step_pending;

  logic                 win_found;
  logic [PTR_W-1:0]     win_idx;
  logic [PTR_W-1:0]     ptr_next;

  // First requester at or after the pointer, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(idx);
      end
    end
  end

  assign ptr_next = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge rt_clk) begin
    if (rt_reset) begin
      state        <= IDLE;
      ptr          <= '0;
      gap_cnt      <= '0;
      step_pending <= 1'b0;
      write_req    <= 1'b0;
      spike_packet <= '0;
      grant        <= '0;
      step_done    <= 1'b0;
      sent_count   <= '0;
    end else begin
      write_req <= 1'b0;
      grant     <= '0;
      step_done <= 1'b0;
      if (step_end) step_pending <= 1'b1;

      case (state)
        IDLE: begin
          // A step_end arriving this cycle is consumed by the close it triggers.
          if (step_pending || step_end) begin
            state        <= CLOSE;
            step_pending <= 1'b0;
          end else if (win_found && !port_full) begin
            state          <= SEND;
            write_req      <= 1'b1;
            grant[win_idx] <= 1'b1;
            spike_packet   <= packet_in[int'(win_idx)*PACKET_SIZE +: PACKET_SIZE];
            ptr            <= ptr_next;
            if (sent_count != '1) sent_count <= sent_count + 1'b1;
          end
        end
        SEND: begin
          gap_cnt <= '0;
          state   <= (GAP_CYCLES > 0) ? GAP : IDLE;
        end
        GAP: begin
          if (gap_cnt == GAP_W'(GAP_LAST)) begin
            gap_cnt <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        CLOSE: begin
          step_done  <= 1'b1;
          sent_count <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_local_port_arbiter.sv
// Directed bench for local_port_arbiter: cycle table plus hand sequences for
// port_full hold, reset mid-gap, round-robin order and count saturation.
module tb_local_port_arbiter;

  logic        rt_clk = 1'b0;
  logic        rt_reset;
  logic [3:0]  req;
  logic [127:0] packet_in;
  logic        port_full;
  logic        step_end;
  logic        write_req;
  logic [31:0] spike_packet;
  logic [3:0]  grant;
  logic        step_done;
  logic [9:0]  sent_count;

  logic [3:0]  req2;
  logic        step_end2;
  logic        write_req2;
  logic [31:0] spike_packet2;
  logic [3:0]  grant2;
  logic        step_done2;
  logic [2:0]  sent_count2;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_pkt;

  always #5 rt_clk = ~rt_clk;

  local_port_arbiter #(.NUM_REQ(4), .PACKET_SIZE(32), .GAP_CYCLES(4), .CNT_WIDTH(10)) dut (
    .rt_clk(rt_clk), .rt_reset(rt_reset), .req(req), .packet_in(packet_in),
    .port_full(port_full), .step_end(step_end), .write_req(write_req),
    .spike_packet(spike_packet), .grant(grant), .step_done(step_done),
    .sent_count(sent_count)
  );

  local_port_arbiter #(.NUM_REQ(4), .PACKET_SIZE(32), .GAP_CYCLES(0), .CNT_WIDTH(3)) dut_sat (
    .rt_clk(rt_clk), .rt_reset(rt_reset), .req(req2), .packet_in(packet_in),
    .port_full(1'b0), .step_end(step_end2), .write_req(write_req2),
    .spike_packet(spike_packet2), .grant(grant2), .step_done(step_done2),
    .sent_count(sent_count2)
  );

  function automatic logic [31:0] pkt(input int i);
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge rt_clk);
    #1;
  endtask

  task automatic check_main(input string tag, input logic wr, input logic [3:0] g,
                            input logic [9:0] cnt, input logic done);
    check({tag, " write_req"}, 32'(write_req), 32'(wr));
    check({tag, " grant"}, 32'(grant), 32'(g));
    check({tag, " sent_count"}, 32'(sent_count), 32'(cnt));
    check({tag, " step_done"}, 32'(step_done), 32'(done));
    check({tag, " spike_packet"}, spike_packet, exp_pkt);
  endtask

  function automatic int onehot_idx(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return 0;
  endfunction

  typedef struct {
    logic [3:0] req;
    logic       pf;
    logic       se;
    logic       wr;
    logic [3:0] g;
    logic [9:0] cnt;
    logic       done;
  } vec_t;

  vec_t vecs[30];

  initial begin
    for (int i = 0; i < 30; i++) vecs[i] = '{4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000, 10'd0, 1'b0};
    // single requester 2, second send 6 cycles later
    vecs[0] = '{4'b0100, 0, 0, 1, 4'b0100, 1, 0};
    for (int i = 1; i <= 5; i++) vecs[i] = '{4'b0100, 0, 0, 0, 4'b0000, 1, 0};
    vecs[6] = '{4'b0100, 0, 0, 1, 4'b0100, 2, 0};
    vecs[7] = '{4'b0000, 0, 0, 0, 4'b0000, 2, 0};
    for (int i = 8; i <= 11; i++) vecs[i] = '{4'b1111, 0, 0, 0, 4'b0000, 2, 0};
    // pointer at 3 after requester 2
    vecs[12] = '{4'b1111, 0, 0, 1, 4'b1000, 3, 0};
    // step_end during SEND of 3rd packet
    vecs[13] = '{4'b1111, 0, 1, 0, 4'b0000, 3, 0};
    for (int i = 14; i <= 18; i++) vecs[i] = '{4'b1111, 0, 0, 0, 4'b0000, 3, 0};
    vecs[19] = '{4'b1111, 0, 0, 0, 4'b0000, 0, 1};
    vecs[20] = '{4'b1111, 0, 0, 1, 4'b0001, 1, 0};
    // two step_end pulses merge into one close
    vecs[21] = '{4'b1111, 0, 1, 0, 4'b0000, 1, 0};
    vecs[22] = '{4'b1111, 0, 0, 0, 4'b0000, 1, 0};
    vecs[23] = '{4'b1111, 0, 1, 0, 4'b0000, 1, 0};
    for (int i = 24; i <= 26; i++) vecs[i] = '{4'b1111, 0, 0, 0, 4'b0000, 1, 0};
    vecs[27] = '{4'b1111, 0, 0, 0, 4'b0000, 0, 1};
    vecs[28] = '{4'b1111, 0, 0, 1, 4'b0010, 1, 0};
    vecs[29] = '{4'b1111, 0, 0, 0, 4'b0000, 1, 0};

    for (int i = 0; i < 4; i++) packet_in[i*32 +: 32] = pkt(i);
    rt_reset = 1'b1; req = '0; port_full = 1'b0; step_end = 1'b0;
    req2 = '0; step_end2 = 1'b0;
    exp_pkt = '0;
    step(); step();
    check_main("reset", 0, 4'b0000, 0, 0);
    check("reset sat count", 32'(sent_count2), 32'd0);
    rt_reset = 1'b0;

    for (int i = 0; i < 30; i++) begin
      req = vecs[i].req; port_full = vecs[i].pf; step_end = vecs[i].se;
      step();
      if (vecs[i].wr) exp_pkt = pkt(onehot_idx(vecs[i].g));
      check_main($sformatf("vec%0d", i), vecs[i].wr, vecs[i].g, vecs[i].cnt, vecs[i].done);
    end
    step_end = 1'b0;

    // port_full held 10 cycles with req[1]
    req = 4'b0010; port_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("full hold %0d write_req", i), 32'(write_req), 32'd0);
    end
    port_full = 1'b0;
    step();
    exp_pkt = pkt(1);
    check_main("full release", 1, 4'b0010, 2, 0);

    // reset mid-GAP with a pending step
    req = 4'b1111; step_end = 1'b1;
    step();
    step_end = 1'b0;
    check_main("pre-reset gap", 0, 4'b0000, 2, 0);
    rt_reset = 1'b1;
    step();
    rt_reset = 1'b0;
    exp_pkt = '0;
    check_main("mid-gap reset", 0, 4'b0000, 0, 0);

    // round robin from requester 0, 6-cycle spacing, no stale close
    for (int s = 0; s < 8; s++) begin
      step();
      exp_pkt = pkt(s % 4);
      check_main($sformatf("rr send%0d", s), 1, 4'(1 << (s % 4)), 10'(s + 1), 0);
      for (int c = 0; c < 5; c++) begin
        step();
        check($sformatf("rr gap%0d.%0d write_req", s, c), 32'(write_req), 32'd0);
        check($sformatf("rr gap%0d.%0d step_done", s, c), 32'(step_done), 32'd0);
      end
    end
    req = '0;

    // saturation: CNT_WIDTH=3, GAP=0
    req2 = 4'b0001;
    for (int s = 1; s <= 9; s++) begin
      step();
      check($sformatf("sat send%0d write_req", s), 32'(write_req2), 32'd1);
      check($sformatf("sat send%0d count", s), 32'(sent_count2), 32'((s > 7) ? 7 : s));
      step();
      check($sformatf("sat idle%0d write_req", s), 32'(write_req2), 32'd0);
    end
    req2 = '0; step_end2 = 1'b1;
    step();
    step_end2 = 1'b0;
    check("sat close count held", 32'(sent_count2), 32'd7);
    check("sat close done early", 32'(step_done2), 32'd0);
    step();
    check("sat step_done", 32'(step_done2), 32'd1);
    check("sat count cleared", 32'(sent_count2), 32'd0);
    step();
    check("sat step_done single", 32'(step_done2), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
